// File: rtl/sine_lut.sv
// Purpose : 1024-point sine lookup (one period per 65536 phase codes) built from a quarter-wave ROM.
// Latency : 2 clocks from i_addr to o_data, one new sample accepted every clock.
// Backpressure: none; the pipeline free-runs and accepts a new phase every cycle.
//
// Ports:
//   i_clk  - sole clock, rising edge
//   i_rst  - synchronous active-high reset; clears both pipeline stages
//   i_addr - 16-bit unsigned phase; [15:14] quadrant, [13:6] table index, [5:0] ignored
//   o_data - signed 16-bit sample, range -32767..+32767, registered
module sine_lut (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [15:0] i_addr,
  output logic [15:0] o_data
);

  typedef logic [255:0][14:0] rom_t;

  // One quarter-wave entry: round(32767 * sin(pi*(2j+1)/1024)).
  // Evaluated only at elaboration; a Taylor series in Q60 unsigned fixed point
  // keeps the error far below the rounding boundary, so the table is exact.
  // Terms alternate in sign, so magnitudes are kept and the sign is applied
  // when accumulating; every partial sum stays positive on [0, pi/2).
  function automatic logic [14:0] quarter_entry(input logic [7:0] j);
    logic [127:0] pi_dec;
    logic [127:0] dec_scale;
    logic [127:0] pi_q;
    logic [127:0] x;
    logic [127:0] x2;
    logic [127:0] term;
    logic [127:0] acc;
    logic [127:0] denom;
    logic [127:0] scaled;
    pi_dec    = 128'd31415926535897932385;
    dec_scale = 128'd10000000000000000000;
    pi_q      = (pi_dec << 60) / dec_scale;
    // angle = pi * (2j+1) / 1024, i.e. the half-LSB offset phase of entry j
    x         = (pi_q * {119'd0, j, 1'b1}) >> 10;
    x2        = (x * x) >> 60;
    term      = x;
    acc       = x;
    for (int n = 1; n <= 15; n++) begin
      denom = 128'((2 * n) * (2 * n + 1));
      term  = ((term * x2) >> 60) / denom;
      if (n[0]) acc = acc - term;
      else      acc = acc + term;
    end
    // All entries are positive, so round-half-up equals round-half-away-from-zero.
    scaled = acc * 128'd32767 + (128'd1 << 59);
    quarter_entry = 15'(scaled >> 60);
  endfunction

  function automatic rom_t build_rom();
    rom_t t;
    t = '0;
    for (int j = 0; j < 256; j++) begin
      t[j] = quarter_entry(8'(j));
    end
    return t;
  endfunction

  localparam rom_t QUARTER_ROM = build_rom();

  // Quadrants 1 and 3 read the table mirrored: 255 - j is simply ~j.
  logic [7:0]  rom_idx;
  logic [14:0] rom_q;
  logic        neg_q;
  logic        unused_phase_lsbs;

  assign rom_idx           = i_addr[14] ? ~i_addr[13:6] : i_addr[13:6];
  assign unused_phase_lsbs = ^i_addr[5:0];

  // Stage 1: synchronous ROM read plus the sign for the lower half-period.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rom_q <= '0;
      neg_q <= 1'b0;
    end else begin
      rom_q <= QUARTER_ROM[rom_idx];
      neg_q <= i_addr[15];
    end
  end

  // Stage 2: apply sign. Entries fit in 15 bits, so the negation cannot
  // reach 0x8000 and never overflows.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_data <= '0;
    end else if (neg_q) begin
      o_data <= 16'd0 - {1'b0, rom_q};
    end else begin
      o_data <= {1'b0, rom_q};
    end
  end

endmodule

// File: tb/tb_sine_lut.sv
// Purpose : self-checking bench for sine_lut against a real-valued sine model.
// Latency : expects every sample exactly 2 clocks after its phase is applied.
// Backpressure: none; stimulus drives one phase per clock.
module tb_sine_lut;

  logic        i_clk;
  logic        i_rst;
  logic [15:0] i_addr;
  logic [15:0] o_data;

  int checks;
  int errors;

  sine_lut dut (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_addr (i_addr),
    .o_data (o_data)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  // Ideal sample for table point k over a full period, no quadrant folding.
  function automatic int model_val(input int k);
    real v;
    v = 32767.0 * $sin(2.0 * 3.14159265358979323846 * (real'(k) + 0.5) / 1024.0);
    if (v >= 0.0) return $rtoi(v + 0.5);
    else          return -$rtoi(-v + 0.5);
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got 0x%04h expected 0x%04h at %0t", name, act, exp, $time);
    end
  endtask

  // Record the inputs seen at each of the last two rising edges.
  logic        h_rst0, h_rst1;
  logic [15:0] h_addr0, h_addr1;
  logic        chk_en;

  initial begin
    h_rst0  = 1'b1;
    h_rst1  = 1'b1;
    h_addr0 = '0;
    h_addr1 = '0;
  end

  always @(posedge i_clk) begin
    h_rst1  <= h_rst0;
    h_addr1 <= h_addr0;
    h_rst0  <= i_rst;
    h_addr0 <= i_addr;
  end

  // Continuous compare: output after edge N reflects the phase at edge N-1,
  // or zero if reset was seen at edge N or N-1.
  always @(negedge i_clk) begin
    if (chk_en) begin
      if (h_rst0 || h_rst1) check("stream_reset", o_data, 16'h0000);
      else check("stream", o_data, 16'(model_val(int'(h_addr1[15:6]))));
    end
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  // Apply a phase, wait for it to emerge, compare against a literal.
  task automatic lit(input string name, input logic [15:0] addr, input logic [15:0] exp);
    i_addr = addr;
    tick();
    tick();
    check(name, o_data, exp);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    chk_en = 1'b0;
    i_rst  = 1'b1;
    i_addr = 16'h0000;

    // Model pins and symmetry of the ideal values.
    check("model_k0",   16'(model_val(0)),   16'h0065);
    check("model_k255", 16'(model_val(255)), 16'h7FFF);
    check("model_k512", 16'(model_val(512)), 16'hFF9B);
    check("model_k768", 16'(model_val(768)), 16'h8001);
    for (int k = 0; k < 512; k++) begin
      check("sym_half",   16'(model_val(k)), 16'(-model_val(k + 512)));
      check("sym_mirror", 16'(model_val(k)), 16'(model_val(511 - k)));
    end

    // Reset held with phase 0, then release.
    tick();
    chk_en = 1'b1;
    tick();
    tick();
    check("reset_state", o_data, 16'h0000);
    i_rst = 1'b0;
    tick();
    check("first_after_release", o_data, 16'h0000);
    tick();
    check("phase0_after_release", o_data, 16'h0065);

    // Directed phases with literal expectations.
    lit("peak_3fc0",   16'h3FC0, 16'h7FFF);
    lit("peak_4000",   16'h4000, 16'h7FFF);
    lit("trough_c000", 16'hC000, 16'h8001);
    lit("neg_8000",    16'h8000, 16'hFF9B);
    lit("neg_ffc0",    16'hFFC0, 16'hFF9B);
    lit("lsbs_003f",   16'h003F, 16'h0065);
    lit("q1_7fc0",     16'h7FC0, 16'h0065);
    lit("q3_bfc0",     16'hBFC0, 16'h8001);

    // Full counter sweep with wrap, one step per clock.
    for (int a = 0; a < 65536 + 256; a++) begin
      i_addr = 16'(a);
      tick();
    end

    // Sweep with a single-cycle reset in the middle.
    for (int a = 0; a < 600; a++) begin
      i_addr = 16'(16'h7000 + 16'(a * 64));
      i_rst  = (a == 300);
      tick();
      if (a == 300) check("midreset_edge", o_data, 16'h0000);
      if (a == 301) check("midreset_next", o_data, 16'h0000);
    end
    i_rst = 1'b0;

    tick();
    tick();
    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
